slice_adder_seq: RTL and testbench

Parametrised, multi-cycle adder/subtractor that processes WIDTH-bit operands one SLICE-bit slice per clock. It generalises the team's 4-bit combinational ripple adder.
- A carry register links slices across cycles, so one narrow ripple chain serves any WIDTH.
- Adds subtract mode, signed-overflow detection and a start/busy/done handshake.
- Sits in the datapath wherever a wide add is needed and area matters more than latency.

---
 rtl/slice_adder_seq.sv | 192 +++++++++++++++++++
 tb/tb_slice_adder_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : slice_adder_seq
//  Description : Multi-cycle adder/subtractor. Adds WIDTH-bit operands one
//                SLICE-bit slice per clock through a single ripple-carry slice.
//                A carry register links the slices across cycles. Provides
//                subtract mode, signed-overflow detection and a
//                start/busy/done handshake.
//  Ports       : clk      - rising-edge clock
//                rst_n    - asynchronous active-low reset
//                start    - request, sampled only in IDLE
//                sub      - 0: A+B, 1: A-B (sampled with start)
//                in_a     - operand A (sampled with start)
//                in_b     - operand B (sampled with start)
//                busy     - high while the slices are being processed
//                done     - one-cycle pulse, out/overflow valid
//                out      - {carry_out, sum}; for sub, MSB=1 means no borrow
//                overflow - two's-complement overflow of the last operation
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  Full-adder cell built from XOR/AND/OR gates.
//  o_co = a.b + (a^b).ci
// ----------------------------------------------------------------------------
module slice_adder_seq_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_ci,
   output logic o_s,
   output logic o_co
);
   logic w_p;

   assign w_p  = i_a ^ i_b;
   assign o_s  = w_p ^ i_ci;
   assign o_co = (i_a & i_b) | (w_p & i_ci);
endmodule

module slice_adder_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   out,
   output logic             overflow
);

   // Guarded division keeps elaboration alive long enough to report the error.
   localparam int NSLICE = (SLICE > 0) ? (WIDTH / SLICE) : 1;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NSLICE - 1);

   if ((SLICE < 1) || ((WIDTH % ((SLICE > 0) ? SLICE : 1)) != 0)) begin : g_bad_params
      $fatal(1, "slice_adder_seq: WIDTH must be a positive multiple of SLICE");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_sub;
   logic               r_carry;
   logic [IDXW-1:0]    r_idx;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;

   logic [SLICE-1:0]   w_a_slc;
   logic [SLICE-1:0]   w_b_slc;
   logic [SLICE-1:0]   w_sum;
   logic [SLICE:0]     w_c;
   logic               w_last;

   // Operands are shifted down one slice per RUN cycle, so the active slice
   // always sits in the low bits; no wide index multiplexer is needed.
   assign w_a_slc = r_a[SLICE-1:0];
   assign w_b_slc = r_b[SLICE-1:0] ^ {SLICE{r_sub}};
   assign w_c[0]  = r_carry;
   assign w_last  = (r_idx == C_LAST_IDX);

   for (genvar i = 0; i < SLICE; i++) begin : g_fa
      slice_adder_seq_fa u_fa (
         .i_a  (w_a_slc[i]),
         .i_b  (w_b_slc[i]),
         .i_ci (w_c[i]),
         .o_s  (w_sum[i]),
         .o_co (w_c[i+1])
      );
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_sub   <= sub;
                  // Subtraction is A + ~B + 1: the +1 enters as carry-in.
                  r_carry <= sub;
                  r_idx   <= '0;
                  r_sum   <= '0;
                  r_cout  <= 1'b0;
                  r_ovf   <= 1'b0;
               end
            end
            S_RUN: begin
               r_a     <= r_a >> SLICE;
               r_b     <= r_b >> SLICE;
               // Each new slice enters at the top and moves down one slice per
               // cycle; after NSLICE cycles slice k lands at bits [k*SLICE +: SLICE].
               // Partial values in between are not meaningful.
               r_sum   <= (r_sum >> SLICE) | (WIDTH'(w_sum) << (WIDTH - SLICE));
               r_carry <= w_c[SLICE];
               r_idx   <= r_idx + 1'b1;
               if (w_last) begin
                  r_cout <= w_c[SLICE];
                  // Carry into the MSB vs. carry out of the MSB.
                  r_ovf  <= w_c[SLICE] ^ w_c[SLICE-1];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out      = {r_cout, r_sum};
   assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_slice_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slice_adder_seq
//  Description : Self-checking bench for slice_adder_seq. Four instances
//                (16/4, 8/8, 32/1, 12/3) share clock and reset; expected
//                results go into a scoreboard queue when an operation is
//                launched and are popped when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slice_adder_seq;

   function automatic int cfg_w(input int g);
      case (g)
         0:       return 16;
         1:       return 8;
         2:       return 32;
         default: return 12;
      endcase
   endfunction

   function automatic int cfg_s(input int g);
      case (g)
         0:       return 4;
         1:       return 8;
         2:       return 1;
         default: return 3;
      endcase
   endfunction

   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       st;
   logic [3:0]       sb;
   logic [3:0][31:0] ia;
   logic [3:0][31:0] ib;
   wire  [3:0]       bz;
   wire  [3:0]       dn;
   wire  [3:0]       ov;
   wire  [3:0][32:0] oo;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [33:0] q[$];   // {overflow, out[32:0]}

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W = cfg_w(g);
      localparam int S = cfg_s(g);
      slice_adder_seq #(.WIDTH(W), .SLICE(S)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .start    (st[g]),
         .sub      (sb[g]),
         .in_a     (ia[g][W-1:0]),
         .in_b     (ib[g][W-1:0]),
         .busy     (bz[g]),
         .done     (dn[g]),
         .out      (oo[g][W:0]),
         .overflow (ov[g])
      );
      if (W < 32) begin : g_pad
         assign oo[g][32:W+1] = '0;
      end
   end

   // Independent arithmetic reference: {overflow, carry, sum}.
   function automatic logic [33:0] ref_model(input int w, input logic s,
                                             input logic [31:0] a, input logic [31:0] b);
      logic [32:0] mask, aa, bb, full;
      logic        ovf;
      mask = (33'h1 << w) - 33'h1;
      aa   = {1'b0, a} & mask;
      bb   = {1'b0, (s ? ~b : b)} & mask;
      full = aa + bb + {32'b0, s};
      ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
      return {ovf, full};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Pop the scoreboard and compare against the DUT outputs.
   task automatic check_result(input int g, input string nm);
      logic [33:0] e;
      if (q.size() == 0) begin
         chk({nm, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = q.pop_front();
         chk({nm, "_out"}, 64'(oo[g]), 64'(e[32:0]));
         chk({nm, "_ovf"}, 64'(ov[g]), 64'(e[33]));
      end
   endtask

   // Bounded wait for done on instance g, counting edges and busy cycles.
   task automatic wait_done(input int g, output int lat, output int nb, output logic ok);
      lat = 0;
      nb  = 0;
      while (!dn[g] && lat < 300) begin
         if (bz[g]) nb++;
         @(negedge clk);
         lat++;
      end
      ok = dn[g];
   endtask

   task automatic do_op(input int g, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [33:0] exp, input string nm);
      int   lat, nb, ns;
      logic ok;
      ns = cfg_w(g) / cfg_s(g);
      @(negedge clk);
      st[g] = 1'b1; sb[g] = s; ia[g] = a; ib[g] = b;
      q.push_back(exp);
      @(negedge clk);
      st[g] = 1'b0;
      wait_done(g, lat, nb, ok);
      chk({nm, "_done_seen"}, 64'(ok), 64'd1);
      if (ok) begin
         check_result(g, nm);
         chk({nm, "_latency"}, 64'(lat), 64'(ns));
         chk({nm, "_busy_cycles"}, 64'(nb), 64'(ns));
         @(negedge clk);
         chk({nm, "_done_single"}, 64'(dn[g]), 64'd0);
         chk({nm, "_out_hold"}, 64'(oo[g]), 64'(exp[32:0]));
      end else if (q.size() != 0) begin
         void'(q.pop_front());
      end
   endtask

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [32:0] eo;
      logic        eov;
   } vec_t;

   vec_t vt[8];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          t1, t2, lat, nb;
      logic        ok, anydone;
      logic [31:0] a, b, msk;
      logic        s;
      int          w;

      vt[0] = '{1'b0, 32'h1234, 32'h4321, 33'h05555, 1'b0};
      vt[1] = '{1'b0, 32'hFFFF, 32'h0001, 33'h10000, 1'b0};
      vt[2] = '{1'b0, 32'h7FFF, 32'h0001, 33'h08000, 1'b1};
      vt[3] = '{1'b1, 32'h0005, 32'h0007, 33'h0FFFE, 1'b0};
      vt[4] = '{1'b1, 32'h8000, 32'h0001, 33'h17FFF, 1'b1};
      vt[5] = '{1'b1, 32'h1234, 32'h1234, 33'h10000, 1'b0};
      vt[6] = '{1'b0, 32'h8000, 32'h8000, 33'h10000, 1'b1};
      vt[7] = '{1'b1, 32'h0000, 32'h0001, 33'h0FFFF, 1'b0};

      st = '0; sb = '0; ia = '0; ib = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(bz[0]), 64'd0);
      chk("reset_done", 64'(dn[0]), 64'd0);
      chk("reset_out",  64'(oo[0]), 64'd0);
      chk("reset_ovf",  64'(ov[0]), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors on the 16/4 instance.
      for (int i = 0; i < 8; i++) begin
         do_op(0, vt[i].s, vt[i].a, vt[i].b, {vt[i].eov, vt[i].eo}, $sformatf("vec%0d", i));
      end

      // Random operations on the 16/4 instance.
      for (int i = 0; i < 6; i++) begin
         a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
         do_op(0, s, a, b, ref_model(16, s, a, b), $sformatf("rnd16_%0d", i));
      end

      // start held high; operands changed during RUN must not matter.
      @(negedge clk);
      st[0] = 1'b1; sb[0] = 1'b0; ia[0] = 32'h0001; ib[0] = 32'h0002;
      q.push_back({1'b0, 33'h00003});
      q.push_back(ref_model(16, 1'b1, 32'hFFFF, 32'hFFFF));
      @(negedge clk);
      ia[0] = 32'hFFFF; ib[0] = 32'hFFFF; sb[0] = 1'b1;
      wait_done(0, lat, nb, ok);
      chk("held_first_done", 64'(ok), 64'd1);
      t1 = cyc;
      if (ok) check_result(0, "held_first");
      @(negedge clk);
      wait_done(0, lat, nb, ok);
      chk("held_second_done", 64'(ok), 64'd1);
      t2 = cyc;
      st[0] = 1'b0;
      if (ok) check_result(0, "held_second");
      chk("held_period", 64'(t2 - t1), 64'd6);
      @(negedge clk);
      @(negedge clk);
      chk("held_no_extra_op", 64'(bz[0]), 64'd0);
      q.delete();

      // Asynchronous reset during RUN cycle 2: abort without done.
      @(negedge clk);
      st[0] = 1'b1; sb[0] = 1'b0; ia[0] = 32'h1234; ib[0] = 32'h0001;
      @(negedge clk);
      st[0] = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(bz[0]), 64'd0);
      chk("abort_done", 64'(dn[0]), 64'd0);
      chk("abort_out",  64'(oo[0]), 64'd0);
      chk("abort_ovf",  64'(ov[0]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      anydone = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         anydone = anydone | dn[0];
      end
      chk("abort_no_done", 64'(anydone), 64'd0);
      do_op(0, 1'b0, 32'h00FF, 32'h0001, {1'b0, 33'h00100}, "after_abort");

      // Parameter sweep: boundary operands plus random ones, per instance.
      for (int g = 1; g < 4; g++) begin
         w   = cfg_w(g);
         msk = 32'((33'h1 << w) - 33'h1);
         do_op(g, 1'b0, msk, 32'h1, ref_model(w, 1'b0, msk, 32'h1), $sformatf("sw%0d_carry", g));
         a = 32'h1 << (w - 1);
         do_op(g, 1'b1, a, 32'h1, ref_model(w, 1'b1, a, 32'h1), $sformatf("sw%0d_minsub", g));
         for (int i = 0; i < 10; i++) begin
            a = $urandom & msk; b = $urandom & msk; s = 1'($urandom_range(0, 1));
            do_op(g, s, a, b, ref_model(w, s, a, b), $sformatf("sw%0d_rnd%0d", g, i));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
